// File: rtl/nibble_frame_pkg.sv
// nibble_frame_pkg: shared state encoding and slot positions for the framed nibble receiver.
//   IDLE  : unlocked, waiting for the first frame sync
//   GUARD : slots 0..SLOT_GUARD_LAST, din must be zero
//   DATA  : slots SLOT_GUARD_LAST+1..SLOT_DATA_LAST, nibbles captured at SLOT_LO and SLOT_HI
//   TAIL  : remaining slots up to FRAME_LEN-1, din ignored
package nibble_frame_pkg;

    typedef enum logic [1:0] {IDLE, GUARD, DATA, TAIL} state_e;

    localparam logic [7:0] SLOT_GUARD_LAST = 8'd3;
    localparam logic [7:0] SLOT_LO         = 8'd5;
    localparam logic [7:0] SLOT_HI         = 8'd7;
    localparam logic [7:0] SLOT_DATA_LAST  = 8'd8;

endpackage

// File: rtl/frame_slot_counter.sv
// frame_slot_counter: 8-bit slot counter that restarts on frame sync and wraps at FRAME_LEN-1.
//   clk, reset (async, active-low)
//   enable : advance qualifier; low holds the count
//   sync   : current cycle is slot 0, so the next slot is 1
//   slot   : slot number of the current cycle (meaningful when sync is low)
//   wrap   : slot is the last slot of the frame
module frame_slot_counter #(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sync,
    output logic [7:0] slot,
    output logic       wrap
);

    localparam logic [7:0] SLOT_LAST = 8'(FRAME_LEN - 1);

    logic [7:0] slot_q, slot_d;

    assign slot = slot_q;
    assign wrap = slot_q == SLOT_LAST;

    always_comb
        slot_d = !enable ? slot_q : sync ? 8'd1 : wrap ? 8'd0 : slot_q + 8'd1;

    always_ff @(posedge clk or negedge reset)
        if (!reset) slot_q <= 8'd0;
        else        slot_q <= slot_d;

endmodule

// File: rtl/nibble_frame_rx.sv
// nibble_frame_rx: locks to frame sync, checks guard slots and assembles slot-5/slot-7 nibbles into a byte.
//   clk, reset (async, active-low)
//   enable     : frame logic qualifier; low freezes slot, state and partial byte
//   sync       : frame start, the enabled sync cycle is slot 0
//   din        : link nibble
//   dout       : assembled byte {slot-7 nibble, slot-5 nibble}, stable while dout_valid
//   dout_valid : byte available, held until dout_ready
//   dout_ready : consumer accept
//   locked     : a sync has been seen since reset
//   guard_err  : one-cycle pulse after a nonzero guard nibble
//   overrun    : one-cycle pulse after a completed byte was dropped
module nibble_frame_rx
    import nibble_frame_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sync,
    input  logic [3:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       locked,
    output logic       guard_err,
    output logic       overrun
);

    state_e     state_q, state_d;
    logic [7:0] slot;
    logic       wrap;
    logic [3:0] lo_q, lo_d;
    logic       bad_q, bad_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       locked_q, locked_d;
    logic       guard_err_q, guard_err_d;
    logic       overrun_q, overrun_d;

    // The counter idles at 0 until the first sync so slot numbering starts clean.
    frame_slot_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .enable (enable && (sync || state_q != IDLE)),
        .sync   (sync),
        .slot   (slot),
        .wrap   (wrap)
    );

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        bad_d        = bad_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        locked_d     = locked_q;
        guard_err_d  = 1'b0;
        overrun_d    = 1'b0;
        if (enable) begin
            if (sync) begin
                // Resync discards any partial frame; this cycle is slot 0.
                state_d  = GUARD;
                locked_d = 1'b1;
                lo_d     = 4'd0;
                bad_d    = 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    GUARD: begin
                        if (din != 4'd0) begin
                            guard_err_d = 1'b1;
                            bad_d       = 1'b1;
                        end
                        if (slot == SLOT_GUARD_LAST) state_d = DATA;
                    end
                    DATA: begin
                        if (slot == SLOT_LO) lo_d = din;
                        if (slot == SLOT_HI && !bad_q) begin
                            if (!dout_valid_q || dout_ready) begin
                                dout_d       = {din, lo_q};
                                dout_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                        // With FRAME_LEN=9 the last data slot is also the frame end.
                        if (slot == SLOT_DATA_LAST) begin
                            state_d = wrap ? GUARD : TAIL;
                            if (wrap) bad_d = 1'b0;
                        end
                    end
                    TAIL: begin
                        if (wrap) begin
                            state_d = GUARD;
                            bad_d   = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            lo_q         <= 4'd0;
            bad_q        <= 1'b0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            guard_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            bad_q        <= bad_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
            guard_err_q  <= guard_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;
    assign guard_err  = guard_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_nibble_frame_rx.sv
// tb_nibble_frame_rx: directed table-driven bench for nibble_frame_rx with FRAME_LEN=16.
module tb_nibble_frame_rx;

    typedef struct {
        logic       en;
        logic       sy;
        logic [3:0] d;
        logic       rdy;
        logic [7:0] e_dout;
        logic       e_val;
        logic       e_lck;
        logic       e_ge;
        logic       e_ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] din = 4'd0;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       guard_err;
    logic       overrun;

    vec_t       vq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         ovr_cnt = 0;
    int         gerr_cnt = 0;
    int         val_cnt = 0;
    logic       r7_val, r7_ovr, r8_ovr;
    logic [7:0] r7_dout;

    nibble_frame_rx #(.FRAME_LEN(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sync       (sync),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .locked     (locked),
        .guard_err  (guard_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic add(input logic en, input logic sy, input logic [3:0] d, input logic rdy,
                       input logic [7:0] ed, input logic ev, input logic el, input logic eg, input logic eo);
        vq.push_back('{en, sy, d, rdy, ed, ev, el, eg, eo});
    endtask

    task automatic addz(input int n, input logic [7:0] ed);
        for (int k = 0; k < n; k++) add(1'b1, 1'b0, 4'd0, 1'b1, ed, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cyc(input logic en, input logic sy, input logic [3:0] d, input logic rdy);
        enable = en;
        sync = sy;
        din = d;
        dout_ready = rdy;
        @(posedge clk);
        #1;
        ovr_cnt += int'(overrun);
        gerr_cnt += int'(guard_err);
        val_cnt += int'(dout_valid);
    endtask

    task automatic frame(input logic [3:0] lo, input logic [3:0] hi, input logic rdy, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            cyc(1'b1, 1'b0, s == 5 ? lo : s == 7 ? hi : 4'h0, rdy);
            if (s == 7) begin
                r7_val = dout_valid;
                r7_dout = dout;
                r7_ovr = overrun;
            end
            if (s == 8) r8_ovr = overrun;
        end
    endtask

    initial begin
        add(1'b0, 1'b1, 4'h0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'h5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        addz(4, 8'h00);
        add(1'b1, 1'b0, 4'hA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        addz(1, 8'h00);
        add(1'b1, 1'b0, 4'h3, 1'b1, 8'h3A, 1'b1, 1'b1, 1'b0, 1'b0);
        addz(8, 8'h3A);
        addz(2, 8'h3A);
        add(1'b1, 1'b0, 4'h1, 1'b1, 8'h3A, 1'b0, 1'b1, 1'b1, 1'b0);
        addz(2, 8'h3A);
        add(1'b1, 1'b0, 4'h5, 1'b1, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
        addz(1, 8'h3A);
        add(1'b1, 1'b0, 4'h7, 1'b1, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
        addz(8, 8'h3A);
        addz(5, 8'h3A);
        add(1'b1, 1'b0, 4'hC, 1'b1, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
        addz(1, 8'h3A);
        add(1'b1, 1'b0, 4'hD, 1'b1, 8'hDC, 1'b1, 1'b1, 1'b0, 1'b0);
        addz(8, 8'hDC);

        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", dout, 8'h00);
        chk("reset valid", dout_valid, 1'b0);
        chk("reset locked", locked, 1'b0);
        chk("reset guard_err", guard_err, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        reset = 1'b1;

        foreach (vq[i]) begin
            cyc(vq[i].en, vq[i].sy, vq[i].d, vq[i].rdy);
            chk($sformatf("v%0d dout", i), dout, vq[i].e_dout);
            chk($sformatf("v%0d valid", i), dout_valid, vq[i].e_val);
            chk($sformatf("v%0d locked", i), locked, vq[i].e_lck);
            chk($sformatf("v%0d guard_err", i), guard_err, vq[i].e_ge);
            chk($sformatf("v%0d overrun", i), overrun, vq[i].e_ov);
        end

        frame(4'h1, 4'h2, 1'b0, 0, 15);
        chk("ovr first valid", r7_val, 1'b1);
        chk("ovr first dout", r7_dout, 8'h21);
        ovr_cnt = 0;
        frame(4'h3, 4'h4, 1'b0, 0, 15);
        chk("ovr pulse slot8", r7_ovr, 1'b1);
        chk("ovr pulse width", r8_ovr, 1'b0);
        chk("ovr pulse count", ovr_cnt, 1);
        chk("ovr dout held", dout, 8'h21);
        chk("ovr valid held", dout_valid, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        chk("ovr accept valid", dout_valid, 1'b0);
        chk("ovr accept dout", dout, 8'h21);

        frame(4'h6, 4'h9, 1'b1, 1, 5);
        val_cnt = 0;
        gerr_cnt = 0;
        repeat (5) cyc(1'b0, 1'b0, 4'hF, 1'b1);
        chk("freeze valid", val_cnt, 0);
        chk("freeze guard_err", gerr_cnt, 0);
        frame(4'h6, 4'h9, 1'b1, 6, 15);
        chk("freeze byte valid", r7_val, 1'b1);
        chk("freeze byte dout", r7_dout, 8'h96);
        chk("freeze frame valid count", val_cnt, 1);

        frame(4'h5, 4'h0, 1'b1, 0, 6);
        val_cnt = 0;
        cyc(1'b1, 1'b1, 4'h0, 1'b1);
        chk("resync no valid", dout_valid, 1'b0);
        chk("resync dout kept", dout, 8'h96);
        frame(4'h2, 4'h1, 1'b0, 1, 15);
        chk("resync new byte valid", r7_val, 1'b1);
        chk("resync new byte dout", r7_dout, 8'h12);
        chk("resync new byte slot", val_cnt, 9);

        frame(4'h0, 4'h0, 1'b0, 0, 5);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("pre-reset valid", dout_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset dout", dout, 8'h00);
        chk("async reset valid", dout_valid, 1'b0);
        chk("async reset locked", locked, 1'b0);
        chk("async reset guard_err", guard_err, 1'b0);
        chk("async reset overrun", overrun, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        reset = 1'b1;
        val_cnt = 0;
        gerr_cnt = 0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 4'(i), 1'b1);
        chk("idle valid count", val_cnt, 0);
        chk("idle guard_err count", gerr_cnt, 0);
        chk("idle locked", locked, 1'b0);
        cyc(1'b1, 1'b1, 4'h0, 1'b1);
        chk("relock", locked, 1'b1);
        frame(4'hE, 4'h7, 1'b1, 1, 8);
        chk("post-reset byte valid", r7_val, 1'b1);
        chk("post-reset byte dout", r7_dout, 8'h7E);
        chk("post-reset accepted", dout_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nibble_frame_rx.md
# nibble_frame_rx

Receive-side counterpart of the framed nibble transmitter. The transmitter emits a 4-bit stream per frame: zeros during guard slots 0–3 and data nibbles on odd slots 5 and 7. This block locks to a frame-sync pulse, checks the guard slots, and captures the two data nibbles. It assembles them into a byte presented on a valid/ready handshake, with guard-error and overrun flags, and sits between the link input pins and the byte consumer.

## Interface
- FRAME_LEN, 16, slots per frame; legal range 9..256; the counter wraps at FRAME_LEN-1.
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately.
- enable  in  1  slot advance/capture qualifier; low freezes the frame logic.
- sync  in  1  frame start; the cycle where sync=1 and enable=1 is slot 0.
- din  in  4  link nibble.
- dout  out  8  assembled byte {slot-7 nibble, slot-5 nibble}.
- dout_valid  out  1  byte available; held until accepted.
- dout_ready  in  1  consumer accepts when dout_valid & dout_ready.
- locked  out  1  a sync has been seen since reset.
- guard_err  out  1  one-cycle pulse: nonzero din in a guard slot.
- overrun  out  1  one-cycle pulse: completed byte dropped because the previous byte was still unaccepted.

## Operation
- Reset values: dout=0, dout_valid=0, locked=0, guard_err=0, overrun=0, slot=0, state=IDLE, low nibble=0, bad flag=0.
- Frame logic is active only in cycles with enable=1. Cycles with enable=0 change no frame state: slot, nibble, bad flag and state hold. The handshake still operates in those cycles.
- IDLE: ignores din and waits for sync. On sync, locked←1, slot←1 and state→GUARD.
- sync=1 in any locked state forces a resync:
  - the current cycle is slot 0 and the next slot is 1;
  - the partial byte and bad flag are discarded and no dout_valid results;
  - no capture happens in that cycle.
- GUARD (slots 0–3): if din≠0, assert guard_err on the next cycle and set the bad flag for this frame. State→DATA after slot 3.
- DATA (slots 4–8):
  - slot 5: din is captured as the low nibble;
  - slot 7: din is captured as the high nibble and the byte completes;
  - slots 4, 6 and 8: din is ignored.
  - State→TAIL after slot 8, or →GUARD if FRAME_LEN=9 and the slot wraps.
- TAIL (slots 9..FRAME_LEN-1): din is ignored. When slot wraps to 0 without sync, state→GUARD and the new frame starts in free-run; sync is not required every frame.
- Byte completion at slot 7, with the bad flag clear:
  - if dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle: dout←byte, dout_valid←1;
  - otherwise the byte is dropped, overrun pulses and dout is unchanged.
- A bad frame never produces dout_valid and never asserts overrun.
- Handshake: dout_valid falls on the edge after a cycle with dout_valid & dout_ready, unless a new byte loads on that same edge. dout is stable while dout_valid=1.
- slot counter is 8 bits and compares modulo FRAME_LEN. Slot arithmetic is unsigned and never saturates.

## Timing
- Capture latency: din sampled in the slot-7 cycle appears on dout with dout_valid=1 on the next edge, which is the slot-8 cycle.
- guard_err and overrun are registered, one cycle after the offending slot, one cycle wide.
- locked rises on the edge after the first enabled sync.
- Back-to-back frames with FRAME_LEN=9 produce one byte every 9 enabled cycles. The consumer must accept within 9 cycles to avoid overrun.
- Asynchronous reset mid-frame: all outputs go to 0 immediately and the pending byte is lost. After release, the block waits in IDLE for sync.
- sync in the slot-7 cycle: resync wins, there is no capture and no dout_valid.

## Structure
- Package nibble_frame_pkg holds:
  - state enum {IDLE, GUARD, DATA, TAIL};
  - localparams SLOT_GUARD_LAST=3, SLOT_LO=5, SLOT_HI=7, SLOT_DATA_LAST=8.
- Sub-module frame_slot_counter: enable, sync, wrap at FRAME_LEN-1, outputs slot and wrap. The FSM, capture and handshake live in the top.

## Test plan
- Reset, then sync; din=0 in slots 0–4, din=4'hA in slot 5, din=4'h3 in slot 7, dout_ready=1 → dout=8'h3A and dout_valid high exactly one cycle in slot 8; locked=1.
- din=4'h1 in slot 2 → guard_err pulse in slot 3; no dout_valid for that frame; the next clean frame delivers normally.
- dout_ready=0 for two free-running frames with bytes 8'h21 and 8'h43 → dout holds 8'h21, overrun pulses once, and after dout_ready=1 dout_valid drops.
- enable=0 for 5 cycles in slot 6 → the slot freezes; resuming yields the correct byte with latency shifted by 5 cycles.
- sync reasserted at slot 7 → no capture and no dout_valid; the new frame aligns to the new slot 0.
- reset asserted in slot 6 while dout_valid=1 → all outputs 0 asynchronously; no output until sync after release.
